// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and parity helper.
// Used by both ends of the uart_tx / uart_rx link.
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Gray-coded so the common frame walk flips one bit per transition
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b011,
    ST_PARITY = 3'b010,
    ST_STOP   = 3'b110
  } uart_state_e;

  function automatic logic parity(input logic [DATA_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Host-side byte handshake of uart_rx.
// valid is a level: it rises when a byte is delivered and stays high until a
// rising edge of ack is seen; data/perr/ferr are stable while valid is high.
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              perr;
  logic              ferr;
  logic              overrun;
  logic              ack;

  modport master (output data, valid, perr, ferr, overrun, input ack);
  modport slave  (input data, valid, perr, ferr, overrun, output ack);

endinterface

// File: rtl/uart_sync.sv
// Reset-to-1 synchronizer chain for the asynchronous rx line, frozen by setb.
// q_early is the stage just before q, i.e. what q will hold one cycle later.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstb,
  input  logic setb,
  input  logic d,
  output logic q,
  output logic q_early
);

  logic [STAGES-1:0] s;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      s <= '1;
    end else if (setb) begin
      s <= {s[STAGES-2:0], d};
    end
  end

  assign q       = s[STAGES-1];
  assign q_early = s[STAGES-2];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, even parity, stop; P = div+2 clk per bit.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote around each bit midpoint.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        setb,
  input  logic        rx,
  input  logic [15:0] div,
  uart_rx_if.master   host,
  output logic        idle,
  output uart_state_e state_dbg
);

  uart_state_e       state;
  logic              rxs;
  logic              rxs_early;
  logic [15:0]       d;
  logic [16:0]       cnt;
  logic [2:0]        idx;
  logic [DATA_W-1:0] sh;
  logic              p;
  logic              ack_d;
  logic              ack_rise;
  logic              start_edge;
  logic              bit_val;
  logic [16:0]       half;
  logic [16:0]       full;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rstb    (rstb),
    .setb    (setb),
    .d       (rx),
    .q       (rxs),
    .q_early (rxs_early)
  );

  // Falling edge caught one stage early so the first sample sits inside the
  // start bit even at P=2.
  assign start_edge = rxs & ~rxs_early;
  assign ack_rise   = host.ack & ~ack_d;
  assign half       = ({1'b0, div} + 17'd2) >> 1;
  assign full       = {1'b0, d} + 17'd1;

`ifdef UART_RX_MAJORITY_EN
  logic v2;
  logic v1;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      v2 <= 1'b1;
      v1 <= 1'b1;
    end else if (setb && state != ST_IDLE) begin
      if (cnt == 17'd2) v2 <= rxs;
      if (cnt == 17'd1) v1 <= rxs;
    end
  end

  assign bit_val = (d >= 16'd2) ? ((v2 & v1) | (v2 & rxs) | (v1 & rxs)) : rxs;
`else
  assign bit_val = rxs;
`endif

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      idx          <= '0;
      sh           <= '0;
      p            <= 1'b0;
      d            <= '0;
      ack_d        <= 1'b0;
      host.data    <= '0;
      host.valid   <= 1'b0;
      host.perr    <= 1'b0;
      host.ferr    <= 1'b0;
      host.overrun <= 1'b0;
    end else if (setb) begin
      ack_d <= host.ack;
      // A completing frame below overrides this clear of valid
      if (ack_rise) begin
        host.valid   <= 1'b0;
        host.overrun <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            d     <= div;
            cnt   <= half;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 17'd1;
          end else if (bit_val == START_BIT) begin
            cnt   <= full;
            idx   <= '0;
            state <= ST_DATA;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 17'd1;
          end else begin
            sh[idx] <= bit_val;
            idx     <= idx + 3'd1;
            cnt     <= full;
            if (idx == 3'd7) state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - 17'd1;
          end else begin
            p     <= bit_val;
            cnt   <= full;
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 17'd1;
          end else begin
            host.data  <= sh;
            host.perr  <= parity(sh) ^ p;
            host.ferr  <= (bit_val != STOP_BIT);
            host.valid <= 1'b1;
            if (host.valid && !ack_rise) host.overrun <= 1'b1;
            // Back-to-back frames at P=2 put the next start edge on this cycle
            if (start_edge) begin
              d     <= div;
              cnt   <= half;
              state <= ST_START;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign idle      = (state == ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: serial frames are built from the
// frame rules, expected bytes/flags queued at send time, and checked by a monitor.
module tb_uart_rx;
  import uart_pkg::*;

  logic        clk;
  logic        rstb;
  logic        setb;
  logic        rx;
  logic [15:0] div;
  logic        idle;
  uart_state_e state_dbg;

  uart_rx_if host ();

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .setb      (setb),
    .rx        (rx),
    .div       (div),
    .host      (host),
    .idle      (idle),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int rx_count = 0;
  int push_count = 0;
  logic [9:0] exp_q[$];
  logic auto_ack = 1'b0;
  logic ack_req = 1'b0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // ack driver: manual requests or automatic one-cycle ack per delivered byte
  initial begin
    host.ack = 1'b0;
    forever begin
      @(negedge clk);
      host.ack = ack_req || (auto_ack && host.valid && !host.ack);
    end
  end

  // monitor: a new byte shows up as a rise of valid, or of overrun while valid is held
  initial begin
    logic v_q, o_q;
    logic [9:0] exp;
    v_q = 1'b0;
    o_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rstb === 1'b1 && ((host.valid === 1'b1 && !v_q) || (host.overrun === 1'b1 && !o_q))) begin
        checks++;
        rx_count++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_byte unexpected byte got %0h expected none", {host.ferr, host.perr, host.data});
        end else begin
          exp = exp_q.pop_front();
          if ({host.ferr, host.perr, host.data} !== exp) begin
            errors++;
            $display("FAIL rx_byte got ferr/perr/data %0h expected %0h", {host.ferr, host.perr, host.data}, exp);
          end
        end
      end
      v_q = (host.valid === 1'b1);
      o_q = (host.overrun === 1'b1);
    end
  end

  // driver: one frame, bits held p cycles each, aligned to the falling clock edge
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_v,
                            input int p, input int freeze_bit, input int rst_bit, input bit push);
    logic frame [11];
    logic sent_par;
    sent_par = (^b) ^ par_flip;
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[i+1] = b[i];
    frame[9]  = sent_par;
    frame[10] = stop_v;
    if (push) begin
      exp_q.push_back({~stop_v, sent_par ^ (^b), b});
      push_count++;
    end
    for (int j = 0; j < 11; j++) begin
      rx = frame[j];
      if (j == freeze_bit) begin
        repeat (p / 2) @(negedge clk);
        setb = 1'b0;
        repeat (20) @(negedge clk);
        setb = 1'b1;
        repeat (p - p / 2) @(negedge clk);
      end else if (j == rst_bit) begin
        repeat (p / 2) @(negedge clk);
        rstb = 1'b0;
        rx   = 1'b1;
        @(negedge clk);
        check("rst_idle", idle, 1);
        check("rst_data", host.data, 0);
        check("rst_valid", host.valid, 0);
        check("rst_perr", host.perr, 0);
        check("rst_ferr", host.ferr, 0);
        check("rst_overrun", host.overrun, 0);
        rstb = 1'b1;
        return;
      end else begin
        repeat (p) @(negedge clk);
      end
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (host.valid !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (host.valid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid still %b after %0d cycles, expected 1", name, host.valid, n);
    end
  endtask

  task automatic do_ack();
    ack_req = 1'b1;
    repeat (2) @(negedge clk);
    ack_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    int p;
    logic [7:0] b;
    rstb = 1'b0;
    setb = 1'b1;
    rx   = 1'b1;
    div  = 16'd5;
    repeat (3) @(negedge clk);
    check("reset_data", host.data, 0);
    check("reset_valid", host.valid, 0);
    check("reset_perr", host.perr, 0);
    check("reset_ferr", host.ferr, 0);
    check("reset_overrun", host.overrun, 0);
    check("reset_idle", idle, 1);
    check("reset_state", state_dbg, ST_IDLE);
    rstb = 1'b1;
    idle_cycles(5);

    // loopback-style frames at P=7
    div = 16'd5;
    send_frame(8'hA5, 1'b0, 1'b1, 7, -1, -1, 1);
    wait_valid("loop_a5");
    do_ack();
    check("loop_a5_acked", host.valid, 0);
    idle_cycles(4);
    send_frame(8'h3C, 1'b0, 1'b1, 7, -1, -1, 1);
    wait_valid("loop_3c");
    do_ack();
    check("loop_3c_acked", host.valid, 0);
    idle_cycles(4);

    // parity error at P=5
    div = 16'd3;
    send_frame(8'h81, 1'b1, 1'b1, 5, -1, -1, 1);
    wait_valid("parity");
    check("parity_perr", host.perr, 1);
    do_ack();
    idle_cycles(4);

    // framing error at P=9, line then held low: no new frame may start
    div = 16'd7;
    send_frame(8'h55, 1'b0, 1'b0, 9, -1, -1, 1);
    wait_valid("framing");
    check("framing_ferr", host.ferr, 1);
    repeat (36) @(negedge clk);
    do_ack();
    check("framing_acked", host.valid, 0);
    check("framing_no_restart", idle, 1);
    idle_cycles(20);
    check("framing_recovered_valid", host.valid, 0);

    // 2-cycle glitch at P=11 is a false start
    div = 16'd9;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle_cycles(30);
    check("glitch_valid", host.valid, 0);
    check("glitch_idle", idle, 1);

    // two frames without ack
    send_frame(8'h12, 1'b0, 1'b1, 11, -1, -1, 1);
    idle_cycles(5);
    send_frame(8'h34, 1'b0, 1'b1, 11, -1, -1, 1);
    idle_cycles(6);
    check("overrun_set", host.overrun, 1);
    check("overrun_data", host.data, 8'h34);
    check("overrun_valid", host.valid, 1);
    do_ack();
    check("overrun_ack_valid", host.valid, 0);
    check("overrun_ack_overrun", host.overrun, 0);
    idle_cycles(4);

    // reset during data bit 4 with a flagged byte held
    div = 16'd5;
    send_frame(8'hF0, 1'b1, 1'b1, 7, -1, -1, 1);
    wait_valid("pre_reset");
    send_frame(8'h5A, 1'b0, 1'b1, 7, -1, 5, 0);
    idle_cycles(40);
    check("post_reset_valid", host.valid, 0);

    // setb low for 20 cycles in the middle of data bit 3
    send_frame(8'h6B, 1'b0, 1'b1, 7, 4, -1, 1);
    wait_valid("freeze");
    do_ack();
    idle_cycles(4);

    // random bytes at the fastest supported rate, random inter-frame gaps
`ifdef UART_RX_MAJORITY_EN
    div = 16'd4;
`else
    div = 16'd0;
`endif
    p = int'(div) + 2;
    auto_ack = 1'b1;
    for (int k = 0; k < 256; k++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b0, 1'b1, p, -1, -1, 1);
      idle_cycles($urandom_range(0, 3));
    end
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    idle_cycles(10);
    check("drain_queue", exp_q.size(), 0);
    check("byte_count", rx_count, push_count);
    check("random_overrun", host.overrun, 0);
    check("random_idle", idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver; the receive end of the team's uart_tx link.
- Frame: start bit (0), 8 data bits LSB first, even-parity bit (XOR of the data bits), stop bit (1).
- Bit period is div+2 clk cycles, the same timing uart_tx produces.
- Delivers each byte with error flags to a host through a level-valid/ack handshake.

Parameters:
- SYNC_STAGES, 2, number of input synchronizer flops on rx (minimum 2).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rstb  input  1  reset, synchronous, active-low.
- setb  input  1  enable; when low, every register holds its value.
- rx  input  1  serial line, asynchronous, idles high.
- div  input  16  bit-period control; period P = div+2 clk cycles.
- ack  input  1  host acknowledge; a rising edge consumes the held byte.
- data  output  8  last received byte.
- valid  output  1  level; byte in data is unconsumed.
- perr  output  1  parity error of the held byte.
- ferr  output  1  stop bit sampled low for the held byte.
- overrun  output  1  sticky; a new frame completed while valid=1.
- idle  output  1  high when the FSM is in IDLE.

Behaviour:
- Reset values (rstb low at posedge clk): data=0, valid=0, perr=0, ferr=0, overrun=0, idle=1. Synchronizer flops reset to 1. FSM goes to IDLE. Counters clear.
- Reset mid-frame aborts the frame; no partial byte is delivered.
- rx passes through SYNC_STAGES flops to give rxs. All sampling uses rxs.
- div is latched into d on the start-edge detection. Changing div mid-frame has no effect on the frame in progress.
- FSM states (gray-coded): IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a falling edge of rxs (1 then 0), load cnt=(div+2)>>1, go to START.
  - START: decrement cnt. At cnt==0 sample rxs:
    - rxs=1: false start, return to IDLE, no flags change.
    - rxs=0: load cnt=d+1, bit index=0, go to DATA.
  - DATA: decrement cnt. At cnt==0 shift the rxs sample into sh[bit index], increment the index and reload cnt=d+1. After index 7 is sampled, go to PARITY.
  - PARITY: at cnt==0 sample rxs into p, reload cnt=d+1, go to STOP.
  - STOP: at cnt==0 sample rxs and complete the frame, then go to IDLE.
- Every bit is sampled at its midpoint. Consecutive samples are exactly P=d+2 cycles apart, because cnt counts d+1 down to 0.
- Frame completion, in a single cycle:
  - data<=sh; perr<=(^sh)^p; ferr<=~stop_sample.
  - If valid=1 and no ack rising edge occurs in the same cycle, set overrun=1; otherwise overrun is unchanged.
  - valid<=1.
- A stop sample of 0 still completes the frame with ferr=1. The FSM returns to IDLE, and the next falling edge is required to start a new frame.
- Ack rising edge: ack is registered into ack_d. An ack rising edge clears valid and overrun on the next posedge.
  - If it coincides with a frame completion, the new byte wins: valid stays 1 and overrun is not set.
- perr and ferr change only at frame completion or reset.
- Latency: valid rises SYNC_STAGES+1 cycles after the stop-bit midpoint on the rx pin.
- div=0 gives P=2 cycles. That rate must still decode correctly when the rx edges are aligned to clk.
- setb=0 freezes all state, including the synchronizer. On resume, operation continues from the held state.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of rxs sampled at cnt==2, 1 and 0 (requires d>=2). The start-bit check uses the same vote. If d<2, the vote degrades to the single sample at cnt==0.
- Not defined: single sample at cnt==0.

Decomposition:
- Package uart_pkg holds:
  - The FSM state typedef and encodings, shared with uart_tx.
  - DATA_W=8.
  - Frame constants START_BIT=0 and STOP_BIT=1.
  - The parity function.
- Sub-module uart_sync (a SYNC_STAGES-deep flop chain with reset to 1 and gated by setb) is natural. Everything else stays in uart_rx.

Test Plan:
- Loopback: uart_tx to uart_rx, div=5 (P=7), send 0xA5 and then 0x3C with ack after each. Required: data=0xA5, then 0x3C; valid pulses high until ack; perr=0, ferr=0.
- Parity error: drive the frame for 0x81 with parity bit 1 (correct value 0), div=3. Required: data=0x81, perr=1, ferr=0.
- Framing error: drive 0x55 with stop bit 0, div=7. Required: ferr=1, valid=1. The FSM must not accept a new frame until rx returns high and falls again.
- Glitch and overrun:
  - A 2-cycle low glitch on rx with div=9 (half period 5). Required: return to IDLE, valid stays 0.
  - Then send two frames without ack. Required: overrun=1, data=second byte. After one ack: valid=0, overrun=0.
- Reset and setb:
  - Assert rstb=0 during DATA bit 4. Required: idle=1 and all outputs 0 on the next cycle.
  - Drop setb for 20 cycles mid-frame while rx holds its level. Required: the byte is still received correctly when rx is stretched to match.
- div=0 (P=2) loopback of 256 random bytes. Required: all bytes match and no flags are set. Repeat with UART_RX_MAJORITY_EN at div=4.
